dm_cache_ctrl: RTL

- Parametrised direct-mapped, read-only instruction/data cache with a full miss-handling state machine.
- Sits between a processor read port and a line-wide backing memory.
- Generalises the current single-size cache in three ways:
  - configurable address width, line count and words per line;
  - an explicit request/ready/valid handshake and a memory refill handshake;
  - a flush sweep, plus hit and miss performance counters.

---
 rtl/dm_cache_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only cache controller with refill handshake, flush sweep
// and saturating hit/miss counters.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cpu_req, cpu_addr     read request and word address {tag, index, offset}
//   flush                 invalidate-all command (wins over cpu_req)
//   cpu_ready             high only while idle; qualifies cpu_req and flush
//   cpu_valid, cpu_rdata  one-cycle data-valid pulse and returned word
//   mem_req, mem_addr     line refill request, held until mem_ack
//   mem_ack, mem_rdata    refill completion and full line (word 0 in LSBs)
//   hit_count, miss_count saturating performance counters
module dm_cache_ctrl #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 1024,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic [ADDR_W-1:0]         cpu_addr,
    output logic                      cpu_ready,
    output logic                      cpu_valid,
    output logic [DATA_W-1:0]         cpu_rdata,
    input  logic                      flush,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [WORDS*DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = WORDS * DATA_W;

    if (ADDR_W <= IDX_W + OFF_W) begin : g_bad_addr_w
        $error("dm_cache_ctrl: ADDR_W leaves no tag bits");
    end

    typedef enum logic [2:0] {
        S_FLUSH   = 3'd0,
        S_IDLE    = 3'd1,
        S_LOOKUP  = 3'd2,
        S_REFILL  = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } entry_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    sweep, sweep_nxt;
    logic [ADDR_W-1:0]   req_addr, req_addr_nxt;

    logic                valid_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                mem_req_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [CNT_W-1:0]    hit_nxt, miss_nxt;

    entry_t              lines_q [LINES];
    entry_t              rd_entry;
    entry_t              wr_entry;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic                hit;

    // Word k of a line sits at bits [(k+1)*DATA_W-1 : k*DATA_W].
    function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] ln,
                                                    input logic [OFF_W-1:0]  off);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (OFF_W'(k) == off) w = ln[k*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_off   = req_addr[OFF_W-1:0];
    assign rd_entry  = lines_q[req_idx];
    assign hit       = rd_entry.valid && (rd_entry.tag == req_tag);
    assign cpu_ready = (state == S_IDLE);

    // Tag/data array: single write port, no reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) lines_q[wr_idx] <= wr_entry;
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FLUSH;
            sweep      <= '0;
            req_addr   <= '0;
            cpu_valid  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state      <= state_nxt;
            sweep      <= sweep_nxt;
            req_addr   <= req_addr_nxt;
            cpu_valid  <= valid_nxt;
            cpu_rdata  <= rdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            hit_count  <= hit_nxt;
            miss_count <= miss_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FLUSH:   if (sweep == IDX_W'(LINES - 1)) state_nxt = S_IDLE;
            S_IDLE: begin
                if (flush)        state_nxt = S_FLUSH;
                else if (cpu_req) state_nxt = S_LOOKUP;
            end
            S_LOOKUP:  state_nxt = hit ? S_IDLE : S_REFILL;
            S_REFILL:  if (mem_ack) state_nxt = S_RESPOND;
            S_RESPOND: state_nxt = S_IDLE;
            default:   state_nxt = S_FLUSH;
        endcase
    end

    // Output, datapath and array-write logic (values for the next cycle).
    always_comb begin
        valid_nxt    = 1'b0;
        rdata_nxt    = cpu_rdata;
        mem_req_nxt  = mem_req;
        mem_addr_nxt = mem_addr;
        hit_nxt      = hit_count;
        miss_nxt     = miss_count;
        sweep_nxt    = '0;
        req_addr_nxt = req_addr;
        wr_en        = 1'b0;
        wr_idx       = sweep;
        wr_entry     = '0;
        case (state)
            S_FLUSH: begin
                // Clearing the whole entry keeps the write a plain RAM write.
                wr_en     = 1'b1;
                wr_idx    = sweep;
                sweep_nxt = sweep + IDX_W'(1);
            end
            S_IDLE: begin
                if (cpu_req && !flush) req_addr_nxt = cpu_addr;
            end
            S_LOOKUP: begin
                if (hit) begin
                    valid_nxt = 1'b1;
                    rdata_nxt = word_sel(rd_entry.data, req_off);
                    hit_nxt   = sat_inc(hit_count);
                end else begin
                    miss_nxt     = sat_inc(miss_count);
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = {req_tag, req_idx, {OFF_W{1'b0}}};
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    wr_en          = 1'b1;
                    wr_idx         = req_idx;
                    wr_entry.valid = 1'b1;
                    wr_entry.tag   = req_tag;
                    wr_entry.data  = mem_rdata;
                    mem_req_nxt    = 1'b0;
                    // Pulse lands in RESPOND with the requested word.
                    valid_nxt      = 1'b1;
                    rdata_nxt      = word_sel(mem_rdata, req_off);
                end
            end
            default: begin
            end
        endcase
    end

endmodule
